// File: rtl/multicycle_controller_pkg.sv
// multicycle_pkg: opcodes, Func bits, ALU codes, FSM states and the
// registered control bundle shared by the multicycle controller files.
package multicycle_pkg;

  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_JUMP  = 4'b0010;
  localparam logic [3:0] OP_BRZ   = 4'b0100;
  localparam logic [3:0] OP_CTYPE = 4'b1000;
  localparam logic [1:0] OP_IMM   = 2'b11;

  localparam int unsigned F_MOVETO   = 0;
  localparam int unsigned F_MOVEFROM = 1;
  localparam int unsigned F_ADD      = 2;
  localparam int unsigned F_SUB      = 3;
  localparam int unsigned F_AND      = 4;
  localparam int unsigned F_OR       = 5;
  localparam int unsigned F_NOT      = 6;
  localparam int unsigned F_NOP      = 7;
  localparam int unsigned F_RSVD     = 8;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_NOT   = 3'b100;
  localparam logic [2:0] ALU_PASSA = 3'b101;
  localparam logic [2:0] ALU_PASSB = 3'b110;

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_JMP    = 4'd6,
    S_BRZ    = 4'd7,
    S_EXEC_C = 4'd8,
    S_EXEC_I = 4'd9,
    S_ALUWB  = 4'd10
  } state_e;

  typedef struct packed {
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       pc_write;
    logic       oldpc_write;
    logic       mdr_write;
    logic       a_write;
    logic       b_write;
    logic       a3_src;
    logic       result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctl;
    logic [1:0] pc_src;
  } ctrl_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: Op/Func/Zero in, enables and selects out.
// master = controller side, slave = datapath side.
interface multicycle_controller_if;

  logic [3:0] Op;
  logic [8:0] Func;
  logic       Zero;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       PCWrite;
  logic       OldPCWrite;
  logic       MDRWrite;
  logic       AWrite;
  logic       BWrite;
  logic       A3Src;
  logic       ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;
  logic [1:0] PCSrc;

  modport master (
    input  Op, Func, Zero,
    output AdrSrc, MemWrite, IRWrite, RegWrite,
    output PCWrite, OldPCWrite, MDRWrite,
    output AWrite, BWrite, A3Src, ResultSrc,
    output ALUSrcA, ALUSrcB, ImmSrc,
    output ALUControl, PCSrc
  );

  modport slave (
    output Op, Func, Zero,
    input  AdrSrc, MemWrite, IRWrite, RegWrite,
    input  PCWrite, OldPCWrite, MDRWrite,
    input  AWrite, BWrite, A3Src, ResultSrc,
    input  ALUSrcA, ALUSrcB, ImmSrc,
    input  ALUControl, PCSrc
  );

endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// alu_decoder: Op/Func -> ALUControl, func_valid (exactly one operative
// Func bit set), is_moveto. Ports: op_i, func_i in; alu_ctl_o, flags out.
module alu_decoder
  import multicycle_pkg::*;
(
  input  logic [3:0] op_i,
  input  logic [8:0] func_i,
  output logic [2:0] alu_ctl_o,
  output logic       func_valid_o,
  output logic       is_moveto_o
);

  logic is_imm;

  assign is_imm = (op_i[3:2] == OP_IMM);

  // NOP and the unassigned top bit count as invalid.
  assign func_valid_o = $onehot(func_i)
                      && !func_i[F_NOP]
                      && !func_i[F_RSVD];

  assign is_moveto_o = (op_i == OP_CTYPE)
                     && func_valid_o
                     && func_i[F_MOVETO];

  always_comb begin
    alu_ctl_o = ALU_ADD;
    if (is_imm) begin
      alu_ctl_o = {1'b0, op_i[1:0]};
    end else if (func_valid_o) begin
      unique case (1'b1)
        func_i[F_MOVETO]:   alu_ctl_o = ALU_PASSA;
        func_i[F_MOVEFROM]: alu_ctl_o = ALU_PASSB;
        func_i[F_ADD]:      alu_ctl_o = ALU_ADD;
        func_i[F_SUB]:      alu_ctl_o = ALU_SUB;
        func_i[F_AND]:      alu_ctl_o = ALU_AND;
        func_i[F_OR]:       alu_ctl_o = ALU_OR;
        func_i[F_NOT]:      alu_ctl_o = ALU_NOT;
        default:            alu_ctl_o = ALU_ADD;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the multicycle datapath. Ports: clk, reset
// (async active-low), bus (master modport), state_o (debug state).
module multicycle_controller
  import multicycle_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus,
  output logic [3:0]              state_o
);

  state_e     state_q, state_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic [2:0] alu_ctl;
  logic       func_valid;
  logic       is_moveto;

  alu_decoder u_alu_dec (
    .op_i         (bus.Op),
    .func_i       (bus.Func),
    .alu_ctl_o    (alu_ctl),
    .func_valid_o (func_valid),
    .is_moveto_o  (is_moveto)
  );

  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          bus.Op == OP_LOAD:      state_d = S_MEMRD;
          bus.Op == OP_STORE:     state_d = S_MEMWR;
          bus.Op == OP_JUMP:      state_d = S_JMP;
          bus.Op == OP_BRZ:       state_d = S_BRZ;
          bus.Op == OP_CTYPE:     state_d = S_EXEC_C;
          bus.Op[3:2] == OP_IMM:  state_d = S_EXEC_I;
          default:                state_d = S_FETCH;
        endcase
      end
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC_C: state_d = func_valid ? S_ALUWB : S_FETCH;
      S_EXEC_I: state_d = S_ALUWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Outputs are decoded from the next state so they register
  // together with it; is_moveto captured here is the held Func copy.
  always_comb begin
    ctrl_d = '0;
    unique case (state_d)
      S_FETCH: begin
        ctrl_d.ir_write    = 1'b1;
        ctrl_d.oldpc_write = 1'b1;
        ctrl_d.alu_src_b   = 2'd1;
        ctrl_d.alu_ctl     = ALU_ADD;
        ctrl_d.pc_write    = 1'b1;
      end
      S_DECODE: begin
        ctrl_d.a_write = 1'b1;
        ctrl_d.b_write = 1'b1;
      end
      S_MEMRD: begin
        ctrl_d.adr_src   = 1'b1;
        ctrl_d.mdr_write = 1'b1;
      end
      S_MEMWB: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.result_src = 1'b1;
      end
      S_MEMWR: begin
        ctrl_d.adr_src   = 1'b1;
        ctrl_d.mem_write = 1'b1;
      end
      S_JMP: begin
        ctrl_d.pc_src   = 2'd1;
        ctrl_d.pc_write = 1'b1;
      end
      S_BRZ: begin
        ctrl_d.alu_src_a = 2'd2;
        ctrl_d.alu_ctl   = ALU_PASSA;
        ctrl_d.pc_src    = 2'd2;
      end
      S_EXEC_C: begin
        ctrl_d.alu_src_a = 2'd2;
        ctrl_d.alu_ctl   = alu_ctl;
      end
      S_EXEC_I: begin
        ctrl_d.alu_src_a = 2'd2;
        ctrl_d.alu_src_b = 2'd2;
        ctrl_d.alu_ctl   = alu_ctl;
      end
      S_ALUWB: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.a3_src    = is_moveto;
      end
      default: ctrl_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RST;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign bus.AdrSrc     = ctrl_q.adr_src;
  assign bus.MemWrite   = ctrl_q.mem_write;
  assign bus.IRWrite    = ctrl_q.ir_write;
  assign bus.RegWrite   = ctrl_q.reg_write;
  // Branch condition is the live Zero flag, not a registered copy.
  assign bus.PCWrite    = ctrl_q.pc_write
                        | ((state_q == S_BRZ) & bus.Zero);
  assign bus.OldPCWrite = ctrl_q.oldpc_write;
  assign bus.MDRWrite   = ctrl_q.mdr_write;
  assign bus.AWrite     = ctrl_q.a_write;
  assign bus.BWrite     = ctrl_q.b_write;
  assign bus.A3Src      = ctrl_q.a3_src;
  assign bus.ResultSrc  = ctrl_q.result_src;
  assign bus.ALUSrcA    = ctrl_q.alu_src_a;
  assign bus.ALUSrcB    = ctrl_q.alu_src_b;
  assign bus.ImmSrc     = 2'b00;
  assign bus.ALUControl = ctrl_q.alu_ctl;
  assign bus.PCSrc      = ctrl_q.pc_src;
  assign state_o        = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-instruction state and
// output sequences are queued from a reference model and compared per cycle.
module tb_multicycle_controller;
  import multicycle_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] state_o;
  logic [21:0] obs;
  int errors = 0;
  int checks = 0;

  multicycle_controller_if bus();

  multicycle_controller dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state_o (state_o)
  );

  always #5 clk = ~clk;

  assign obs = {bus.AdrSrc, bus.MemWrite, bus.IRWrite,
                bus.RegWrite, bus.PCWrite, bus.OldPCWrite,
                bus.MDRWrite, bus.AWrite, bus.BWrite,
                bus.A3Src, bus.ResultSrc, bus.ALUSrcA,
                bus.ALUSrcB, bus.ImmSrc, bus.ALUControl,
                bus.PCSrc};

  typedef struct {
    string       name;
    state_e      st;
    logic [3:0]  op;
    logic [8:0]  fn;
    logic        z;
    logic [21:0] outs;
    logic [21:0] mask;
  } exp_t;

  exp_t sb[$];

  function automatic logic [2:0] cfunc(logic [8:0] fn);
    case (fn)
      9'h001:  return 3'b101;
      9'h002:  return 3'b110;
      9'h004:  return 3'b000;
      9'h008:  return 3'b001;
      9'h010:  return 3'b010;
      9'h020:  return 3'b011;
      9'h040:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic fvalid(logic [8:0] fn);
    return fn inside {9'h001, 9'h002, 9'h004, 9'h008,
                      9'h010, 9'h020, 9'h040};
  endfunction

  // Bit map of obs: 21 AdrSrc, 20 MemWrite, 19 IRWrite, 18 RegWrite,
  // 17 PCWrite, 16 OldPCWrite, 15 MDRWrite, 14 AWrite, 13 BWrite,
  // 12 A3Src, 11 ResultSrc, 10:9 SrcA, 8:7 SrcB, 6:5 Imm, 4:2 ALU, 1:0 PCSrc
  function automatic logic [21:0] spec_out(state_e s, logic [3:0] op,
                                           logic [8:0] fn, logic z);
    logic [21:0] v;
    v = '0;
    case (s)
      S_FETCH: begin
        v[19] = 1'b1; v[16] = 1'b1; v[17] = 1'b1; v[8:7] = 2'd1;
      end
      S_DECODE: begin v[14] = 1'b1; v[13] = 1'b1; end
      S_MEMRD:  begin v[21] = 1'b1; v[15] = 1'b1; end
      S_MEMWB:  begin v[18] = 1'b1; v[11] = 1'b1; end
      S_MEMWR:  begin v[21] = 1'b1; v[20] = 1'b1; end
      S_JMP:    begin v[1:0] = 2'd1; v[17] = 1'b1; end
      S_BRZ: begin
        v[10:9] = 2'd2; v[4:2] = 3'b101; v[1:0] = 2'd2; v[17] = z;
      end
      S_EXEC_C: begin v[10:9] = 2'd2; v[4:2] = cfunc(fn); end
      S_EXEC_I: begin
        v[10:9] = 2'd2; v[8:7] = 2'd2; v[4:2] = {1'b0, op[1:0]};
      end
      S_ALUWB: begin
        v[18] = 1'b1;
        v[12] = (op == 4'b1000) && (fn == 9'h001);
      end
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic void push_instr(string n, logic [3:0] op,
                                     logic [8:0] fn, logic z);
    state_e seq[$];
    seq.push_back(S_DECODE);
    if (op == 4'b0000) begin
      seq.push_back(S_MEMRD); seq.push_back(S_MEMWB);
    end else if (op == 4'b0001) seq.push_back(S_MEMWR);
    else if (op == 4'b0010) seq.push_back(S_JMP);
    else if (op == 4'b0100) seq.push_back(S_BRZ);
    else if (op == 4'b1000) begin
      seq.push_back(S_EXEC_C);
      if (fvalid(fn)) seq.push_back(S_ALUWB);
    end else if (op[3:2] == 2'b11) begin
      seq.push_back(S_EXEC_I); seq.push_back(S_ALUWB);
    end
    seq.push_back(S_FETCH);
    foreach (seq[i]) begin
      exp_t e;
      e.name = n; e.st = seq[i];
      e.op = op; e.fn = fn; e.z = z;
      e.outs = spec_out(seq[i], op, fn, z);
      e.mask = (seq[i] == S_EXEC_C && !fvalid(fn)) ? ~22'h1C : '1;
      sb.push_back(e);
    end
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    bus.Op = 4'h0; bus.Func = 9'h0; bus.Zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (state_o !== 4'(S_RST) || obs !== '0) begin
      errors++;
      $display("FAIL reset_hold: state=%0d outs=%h want 0/0",
               state_o, obs);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (state_o !== 4'(S_RST) || obs !== '0) begin
      errors++;
      $display("FAIL reset_release: state=%0d outs=%h want 0/0",
               state_o, obs);
    end
    @(posedge clk); #1;
    checks++;
    if (state_o !== 4'(S_FETCH) ||
        obs !== spec_out(S_FETCH, 4'h0, 9'h0, 1'b0)) begin
      errors++;
      $display("FAIL reset_fetch: state=%0d outs=%h want %0d/%h",
               state_o, obs, S_FETCH,
               spec_out(S_FETCH, 4'h0, 9'h0, 1'b0));
    end
  endtask

  task automatic drain(string tag);
    int budget = 64;
    while (sb.size() != 0 && budget > 0) begin
      exp_t e;
      e = sb.pop_front();
      budget--;
      bus.Op = e.op; bus.Func = e.fn; bus.Zero = e.z;
      @(posedge clk); #1;
      checks++;
      if (state_o !== 4'(e.st)) begin
        errors++;
        $display("FAIL %s/%s state: got %0d want %0d",
                 tag, e.name, state_o, e.st);
      end
      checks++;
      if ((obs & e.mask) !== (e.outs & e.mask)) begin
        errors++;
        $display("FAIL %s/%s outs in %s: got %h want %h",
                 tag, e.name, e.st.name(), obs & e.mask,
                 e.outs & e.mask);
      end
    end
  endtask

  task automatic test_memory();
    push_instr("load_0123", 4'b0000, 9'h123, 1'b0);
    push_instr("store", 4'b0001, 9'h0F0, 1'b1);
    drain("memory");
  endtask

  task automatic test_branch();
    push_instr("jump", 4'b0010, 9'h1AB, 1'b0);
    push_instr("brz_z1", 4'b0100, 9'h055, 1'b1);
    push_instr("brz_z0", 4'b0100, 9'h055, 1'b0);
    drain("branch");
  endtask

  task automatic test_ctype();
    logic [8:0] fns [0:8];
    fns = '{9'h001, 9'h003, 9'h002, 9'h004, 9'h008,
            9'h010, 9'h020, 9'h040, 9'h080};
    foreach (fns[i])
      push_instr($sformatf("ctype_%03h", fns[i]), 4'b1000,
                 fns[i], 1'b0);
    drain("ctype");
  endtask

  task automatic test_imm();
    for (int i = 12; i < 16; i++)
      push_instr($sformatf("imm_op%0d", i), 4'(i), 9'h001, 1'b0);
    drain("imm");
  endtask

  task automatic test_nop();
    push_instr("op0011", 4'b0011, 9'h001, 1'b0);
    push_instr("op1001", 4'b1001, 9'h004, 1'b1);
    push_instr("op0111", 4'b0111, 9'h001, 1'b0);
    drain("nop");
  endtask

  task automatic test_reset_mid();
    bus.Op = 4'b0001; bus.Func = 9'h0AA; bus.Zero = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (state_o !== 4'(S_MEMWR) || bus.MemWrite !== 1'b1) begin
      errors++;
      $display("FAIL mid_memwr: state=%0d mw=%b want %0d/1",
               state_o, bus.MemWrite, S_MEMWR);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (state_o !== 4'(S_RST) || obs !== '0) begin
      errors++;
      $display("FAIL mid_async: state=%0d outs=%h want 0/0",
               state_o, obs);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++;
    if (state_o !== 4'(S_RST) || obs !== '0) begin
      errors++;
      $display("FAIL mid_release: state=%0d outs=%h want 0/0",
               state_o, obs);
    end
    @(posedge clk); #1;
    checks++;
    if (state_o !== 4'(S_FETCH) ||
        obs !== spec_out(S_FETCH, 4'h1, 9'h0AA, 1'b0)) begin
      errors++;
      $display("FAIL mid_fetch: state=%0d outs=%h", state_o, obs);
    end
    push_instr("after_rst", 4'b0000, 9'h011, 1'b0);
    drain("mid");
  endtask

  initial begin
    test_reset();
    test_memory();
    test_branch();
    test_ctype();
    test_imm();
    test_nop();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left: %0d entries want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: no finish by 200000 want finish");
    $fatal(1, "timeout");
  end

endmodule
